ex_hazard_ctrl: RTL and testbench
=================================

// Module: ex_hazard_ctrl
// PURPOSE
//  Forwarding and hazard controller for the execute stage of the 16-bit pipeline.
//  Tracks destination registers of in-flight instructions in EX, MEM and WB.
//  Registers the 3-bit operand-forward selects used by the EX-stage ALU input muxes.
//  Generates load-use stall, branch flush, and CCR-dependency forwarding.
// PARAMETERS
//  REG_ADDR_W  3  register-file address width (8 architectural registers)
//  PC_REG      7  register index aliased to PC; never forwarded, never a stall source
// PORTS
//  clk             in   1  rising-edge clock
//  reset           in   1  asynchronous, active-low reset
//  id_valid        in   1  ID-stage instruction is real (not bubble)
//  id_rs1          in   3  source register feeding ALU input 1
//  id_rs2          in   3  source register feeding ALU input 2
//  id_use_rs1      in   1  instruction reads id_rs1
//  id_use_rs2      in   1  instruction reads id_rs2
//  id_rd           in   3  destination register
//  id_rd_write     in   1  instruction writes id_rd
//  id_is_load      in   1  instruction is a load (result available after MEM)
//  id_ccr_write    in   1  instruction updates CCR
//  id_ccr_use      in   1  instruction is flag-conditional (reads CCR)
//  ex_branch_taken in   1  branch/jump resolved taken in EX this cycle
//  ex_fwd_sel1     out  3  ALU input-1 mux select
//  ex_fwd_sel2     out  3  ALU input-2 mux select
//  ex_ccr_fwd      out  1  conditional in EX takes flags from CCRTemp path, not CCR reg
//  ex_valid        out  1  instruction in EX is real; gates RF/CCR/memory writes
//  stall           out  1  hold PC and IF/ID; insert bubble into EX
//  flush           out  1  kill IF/ID contents
// BEHAVIOUR
//  Reset (async, reset=0): EX/MEM/WB tracking entries invalid; all outputs 0.
//  Tracking entry per stage: {valid, rd, rd_write, is_load, ccr_write}.
//  Each rising edge: WB<=MEM, MEM<=EX, EX<=ID entry; ID entry is bubble if
//   stall, flush, or !id_valid.
//  Select encoding (registered, valid while instruction is in EX):
//   0 register-file/immediate path (no forward)
//   1 EX/MEM ALU result (producer one ahead)
//   2 MEM/WB ALU result (producer two ahead, non-load)
//   3 MEM/WB load data (producer two ahead, load)
//   4 retired-value latch (producer three ahead; RF has no write-through)
//   5-7 never driven
//  Select computation, per operand, on the cycle before EX entry:
//   compare rsN against EX, MEM and WB entries that are valid and rd_write.
//   EX match -> 1; MEM match -> 2 or 3 (by is_load); WB match -> 4.
//   Youngest match wins (EX > MEM > WB). No match, !id_use_rsN,
//   or rsN==PC_REG -> 0.
//  Load-use stall: combinational stall=1 when id_valid and an operand in use
//   matches an EX entry with is_load=1 (rs != PC_REG).
//   Exactly one cycle; next cycle the load sits in MEM -> select 3 on EX entry.
//  CCR: ex_ccr_fwd=1 when the EX entry has ccr_use and the MEM entry
//   (previous instruction) is valid with ccr_write; else 0.
//   A bubble between producer and consumer -> 0.
//  Flush: flush=ex_branch_taken, combinational.
//   Next edge: ID entry captured as bubble; EX entry cleared (ex_valid=0, sels=0).
//  Simultaneous flush and stall: flush wins; stall forced 0, since the ID
//   instruction is killed.
//  ex_valid follows the EX entry valid bit. Bubbles always produce sels=0, ex_ccr_fwd=0.
//  Reset mid-operation clears all in-flight entries immediately; no partial state.
// TESTING
//  ADD r1 then ADD r2,r1,r3 back-to-back -> 2nd in EX: ex_fwd_sel1=1, sel2=0, stall never 1.
//  ADD r1; NOP; ADD r4,r5,r1 -> ex_fwd_sel2=2; same with LW r1 as producer -> ex_fwd_sel2=3.
//  LW r2; ADD r3,r2,r2 -> stall=1 for exactly 1 cycle, bubble in EX (ex_valid=0),
//   then ex_fwd_sel1=ex_fwd_sel2=3.
//  ADD r1; NOP; NOP; ADD r6,r1,r7 -> sel1=4, sel2=0 (PC_REG never forwarded).
//  LW r2 in EX while ex_branch_taken=1 and ID needs r2 -> flush=1, stall=0,
//   next cycle ex_valid=0 and sels=0.
//  ADD (ccr_write) then ADC -> ex_ccr_fwd=1; assert reset=0 mid-sequence ->
//   all outputs 0 immediately, no stale selects after release.

Source files
------------

// File: rtl/ex_hazard_ctrl_if.sv
// ID/EX-side signal bundle for the execute-stage forwarding and hazard controller.
// master drives the decoded ID fields and branch resolution; slave returns selects and stall/flush.
interface ex_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_rd_write;
  logic                  id_is_load;
  logic                  id_ccr_write;
  logic                  id_ccr_use;
  logic                  ex_branch_taken;
  logic [2:0]            ex_fwd_sel1;
  logic [2:0]            ex_fwd_sel2;
  logic                  ex_ccr_fwd;
  logic                  ex_valid;
  logic                  stall;
  logic                  flush;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_write,
           id_is_load, id_ccr_write, id_ccr_use, ex_branch_taken,
    input  ex_fwd_sel1, ex_fwd_sel2, ex_ccr_fwd, ex_valid, stall, flush
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_write,
           id_is_load, id_ccr_write, id_ccr_use, ex_branch_taken,
    output ex_fwd_sel1, ex_fwd_sel2, ex_ccr_fwd, ex_valid, stall, flush
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage forwarding/hazard controller: tracks EX/MEM/WB destinations, registers
// ALU operand-forward selects, and raises load-use stall, branch flush and CCR forwarding.
module ex_hazard_ctrl #(
  parameter int                    REG_ADDR_W = 3,
  parameter logic [REG_ADDR_W-1:0] PC_REG     = 3'd7
) (
  input logic         clk,
  input logic         reset,
  ex_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_write;
    logic                  is_load;
    logic                  ccr_write;
  } entry_t;

  entry_t     ex_q, mem_q, wb_q;
  logic       ex_ccr_use_q;
  logic [2:0] ex_sel1_q, ex_sel2_q;

  entry_t     id_entry;
  logic       id_ccr_use;
  logic [2:0] id_sel1, id_sel2;
  logic       flush_int, stall_int;
  logic       ld_hit1, ld_hit2;

  function automatic logic hit(input entry_t e, input logic [REG_ADDR_W-1:0] rs);
    return e.valid && e.rd_write && (e.rd == rs);
  endfunction

  // Youngest producer wins; PC alias is always read from the normal path.
  function automatic logic [2:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input logic use_rs,
                                         input entry_t ex_e, input entry_t mem_e,
                                         input entry_t wb_e);
    if (!use_rs || rs == PC_REG) return 3'd0;
    if (hit(ex_e, rs))           return 3'd1;
    if (hit(mem_e, rs))          return mem_e.is_load ? 3'd3 : 3'd2;
    if (hit(wb_e, rs))           return 3'd4;
    return 3'd0;
  endfunction

  always_comb begin
    flush_int = reset & bus.ex_branch_taken;
    ld_hit1   = bus.id_use_rs1 && bus.id_rs1 != PC_REG && hit(ex_q, bus.id_rs1) && ex_q.is_load;
    ld_hit2   = bus.id_use_rs2 && bus.id_rs2 != PC_REG && hit(ex_q, bus.id_rs2) && ex_q.is_load;
    stall_int = reset & bus.id_valid & ~flush_int & (ld_hit1 | ld_hit2);

    id_entry   = '0;
    id_ccr_use = 1'b0;
    id_sel1    = 3'd0;
    id_sel2    = 3'd0;
    if (bus.id_valid && !stall_int && !flush_int) begin
      id_entry.valid     = 1'b1;
      id_entry.rd        = bus.id_rd;
      id_entry.rd_write  = bus.id_rd_write;
      id_entry.is_load   = bus.id_is_load;
      id_entry.ccr_write = bus.id_ccr_write;
      id_ccr_use         = bus.id_ccr_use;
      id_sel1            = fwd_sel(bus.id_rs1, bus.id_use_rs1, ex_q, mem_q, wb_q);
      id_sel2            = fwd_sel(bus.id_rs2, bus.id_use_rs2, ex_q, mem_q, wb_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      ex_ccr_use_q <= 1'b0;
      ex_sel1_q    <= 3'd0;
      ex_sel2_q    <= 3'd0;
    end else begin
      wb_q         <= mem_q;
      mem_q        <= ex_q;
      ex_q         <= id_entry;
      ex_ccr_use_q <= id_ccr_use;
      ex_sel1_q    <= id_sel1;
      ex_sel2_q    <= id_sel2;
    end
  end

  assign bus.ex_fwd_sel1 = ex_sel1_q;
  assign bus.ex_fwd_sel2 = ex_sel2_q;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_ccr_fwd  = ex_q.valid & ex_ccr_use_q & mem_q.valid & mem_q.ccr_write;
  assign bus.stall       = stall_int;
  assign bus.flush       = flush_int;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: forwarding selects, load-use stall, flush, CCR forward, reset.
module tb_ex_hazard_ctrl;
  logic clk;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ex_hazard_ctrl_if #(.REG_ADDR_W(3)) bus ();

  ex_hazard_ctrl #(.REG_ADDR_W(3), .PC_REG(3'd7)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic u1, input logic u2, input logic [2:0] rd,
                        input logic rdw, input logic ld, input logic ccrw, input logic ccru);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_rd        = rd;
    bus.id_rd_write  = rdw;
    bus.id_is_load   = ld;
    bus.id_ccr_write = ccrw;
    bus.id_ccr_use   = ccru;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic drain();
    nop(); nop(); nop();
  endtask

  initial begin
    reset = 1'b0;
    bus.ex_branch_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_sel1", bus.ex_fwd_sel1, 0);
    chk("rst_sel2", bus.ex_fwd_sel2, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_flush", bus.flush, 0);
    reset = 1'b1;
    step();

    // ADD r1 ; ADD r2,r1,r3
    set_id(1, 0, 0, 1, 1, 1, 1, 0, 0, 0); step();
    set_id(1, 1, 3, 1, 1, 2, 1, 0, 0, 0); #1;
    chk("a_stall", bus.stall, 0);
    step();
    chk("a_valid", bus.ex_valid, 1);
    chk("a_sel1", bus.ex_fwd_sel1, 1);
    chk("a_sel2", bus.ex_fwd_sel2, 0);
    drain();

    // ADD r1 ; NOP ; ADD r4,r5,r1
    set_id(1, 0, 0, 1, 1, 1, 1, 0, 0, 0); step();
    nop();
    set_id(1, 5, 1, 1, 1, 4, 1, 0, 0, 0); step();
    chk("b_sel1", bus.ex_fwd_sel1, 0);
    chk("b_sel2", bus.ex_fwd_sel2, 2);
    drain();

    // LW r1 ; NOP ; ADD r4,r5,r1
    set_id(1, 3, 0, 1, 0, 1, 1, 1, 0, 0); step();
    nop();
    set_id(1, 5, 1, 1, 1, 4, 1, 0, 0, 0); #1;
    chk("b_ld_stall", bus.stall, 0);
    step();
    chk("b_ld_sel2", bus.ex_fwd_sel2, 3);
    drain();

    // LW r2 ; ADD r3,r2,r2 -> one-cycle stall
    set_id(1, 4, 0, 1, 0, 2, 1, 1, 0, 0); step();
    set_id(1, 2, 2, 1, 1, 3, 1, 0, 0, 0); #1;
    chk("c_stall1", bus.stall, 1);
    step();
    chk("c_bubble_valid", bus.ex_valid, 0);
    chk("c_bubble_sel1", bus.ex_fwd_sel1, 0);
    chk("c_bubble_sel2", bus.ex_fwd_sel2, 0);
    chk("c_stall2", bus.stall, 0);
    step();
    chk("c_valid", bus.ex_valid, 1);
    chk("c_sel1", bus.ex_fwd_sel1, 3);
    chk("c_sel2", bus.ex_fwd_sel2, 3);
    drain();

    // ADD r1 ; NOP ; ADD r7 ; ADD r6,r1,r7
    set_id(1, 0, 0, 1, 1, 1, 1, 0, 0, 0); step();
    nop();
    set_id(1, 0, 0, 1, 1, 7, 1, 0, 0, 0); step();
    set_id(1, 1, 7, 1, 1, 6, 1, 0, 0, 0); step();
    chk("d_sel1", bus.ex_fwd_sel1, 4);
    chk("d_sel2_pc", bus.ex_fwd_sel2, 0);
    drain();

    // LW r2 in EX, branch taken, ID needs r2
    set_id(1, 4, 0, 1, 0, 2, 1, 1, 0, 0); step();
    set_id(1, 2, 2, 1, 1, 3, 1, 0, 0, 0);
    bus.ex_branch_taken = 1'b1; #1;
    chk("e_flush", bus.flush, 1);
    chk("e_stall", bus.stall, 0);
    step();
    bus.ex_branch_taken = 1'b0;
    chk("e_valid", bus.ex_valid, 0);
    chk("e_sel1", bus.ex_fwd_sel1, 0);
    chk("e_sel2", bus.ex_fwd_sel2, 0);
    #1;
    chk("e_flush_off", bus.flush, 0);
    drain();

    // ADD(ccr) ; NOP ; ADC -> no CCR forward across a bubble
    set_id(1, 0, 0, 1, 1, 1, 1, 0, 1, 0); step();
    nop();
    set_id(1, 2, 3, 1, 1, 4, 1, 0, 0, 1); step();
    chk("f_ccr_bubble", bus.ex_ccr_fwd, 0);
    drain();

    // ADD r1 (ccr) ; ADC r5,r1,r2 -> CCR forward, then reset mid-sequence
    set_id(1, 0, 0, 1, 1, 1, 1, 0, 1, 0); step();
    set_id(1, 1, 2, 1, 1, 5, 1, 0, 1, 1); step();
    chk("f_ccr_fwd", bus.ex_ccr_fwd, 1);
    chk("f_sel1", bus.ex_fwd_sel1, 1);
    reset = 1'b0; #1;
    chk("r_ex_valid", bus.ex_valid, 0);
    chk("r_sel1", bus.ex_fwd_sel1, 0);
    chk("r_ccr_fwd", bus.ex_ccr_fwd, 0);
    chk("r_stall", bus.stall, 0);
    chk("r_flush", bus.flush, 0);
    #2;
    reset = 1'b1;
    set_id(1, 1, 5, 1, 1, 6, 1, 0, 0, 1); step();
    chk("r_post_valid", bus.ex_valid, 1);
    chk("r_post_sel1", bus.ex_fwd_sel1, 0);
    chk("r_post_sel2", bus.ex_fwd_sel2, 0);
    chk("r_post_ccr", bus.ex_ccr_fwd, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
